oam_dma: RTL

Sprite-DMA engine that sits directly upstream of the main memory block and shares its single-port bus (clk, reset_n, we, addr, din, dout).
- Snoops CPU writes; a write of page value P to TRIGGER_ADDR starts a transfer.
- Stalls the CPU, then performs 256 read/write pairs: read byte {P, idx} from memory, write it to OAM_DATA_ADDR.
- While busy it owns the memory bus; the top-level mux selects DMA outputs when dma_busy=1.

---
 rtl/oam_dma_pkg.sv | 8 +
 rtl/oam_dma_if.sv | 21 ++
 rtl/oam_dma.sv | 77 +++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared widths, bus addresses and FSM encoding for the sprite DMA
package oam_dma_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int REG_WIDTH = 8;
  localparam logic [ADDR_WIDTH-1:0] OAM_DMA_TRIGGER = 16'h4014;
  localparam logic [ADDR_WIDTH-1:0] OAM_DATA = 16'h2004;
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_e;
endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU snoop and memory-side bus of the sprite DMA; slave is the DMA view
interface oam_dma_if;
  import oam_dma_pkg::*;
  logic cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [REG_WIDTH-1:0] cpu_din;
  logic cpu_rdy;
  logic dma_busy;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_we;
  logic [REG_WIDTH-1:0] mem_din;
  logic [REG_WIDTH-1:0] mem_dout;
  modport slave (
    input cpu_we, cpu_addr, cpu_din, mem_dout,
    output cpu_rdy, dma_busy, mem_addr, mem_we, mem_din
  );
  modport master (
    output cpu_we, cpu_addr, cpu_din, mem_dout,
    input cpu_rdy, dma_busy, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA copying page {P,00..FF} to the OAM data port; OAM_DMA_ODD_ALIGN_EN adds an align cycle on odd parity
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = OAM_DMA_TRIGGER,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = OAM_DATA
) (
  input logic clk,
  input logic reset_n,
  oam_dma_if.slave bus
);
  state_e state_q, state_d;
  logic [REG_WIDTH-1:0] page_q, page_d, idx_q, idx_d;
  logic trig;
  state_e halt_next;
  assign trig = bus.cpu_we && (bus.cpu_addr == TRIGGER_ADDR);
`ifdef OAM_DMA_ODD_ALIGN_EN
  logic parity_q, parity_d;
  assign parity_d = ~parity_q;
  assign halt_next = parity_q ? ALIGN : READ;
  // free-running get/put parity, counted from reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) parity_q <= 1'b0;
    else parity_q <= parity_d;
`else
  assign halt_next = READ;
`endif
  // state, page and byte index registers; reset aborts any transfer at once
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      page_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      page_q <= page_d;
      idx_q <= idx_d;
    end
  // next state and bus outputs; WRITE forwards the byte read in the previous READ
  always_comb begin
    state_d = state_q;
    page_d = page_q;
    idx_d = idx_q;
    bus.cpu_rdy = 1'b0;
    bus.dma_busy = 1'b1;
    bus.mem_addr = '0;
    bus.mem_we = 1'b0;
    bus.mem_din = '0;
    case (state_q)
      IDLE: begin
        bus.cpu_rdy = 1'b1;
        bus.dma_busy = 1'b0;
        if (trig) begin
          state_d = HALT;
          page_d = bus.cpu_din;
          idx_d = '0;
        end
      end
      HALT: state_d = halt_next;
`ifdef OAM_DMA_ODD_ALIGN_EN
      ALIGN: state_d = READ;
`endif
      READ: begin
        bus.mem_addr = {page_q, idx_q};
        state_d = WRITE;
      end
      WRITE: begin
        bus.mem_addr = OAM_DATA_ADDR;
        bus.mem_we = 1'b1;
        bus.mem_din = bus.mem_dout;
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == 8'hFF) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
